// File: rtl/mac_acc_block_if.sv
// Handshake bundle between the multiply stage, the accumulator and the next stage.
// Carries product beats in and group results out.
interface mac_acc_block_if #(
    parameter int unsigned INT_WIDTH = 40,
    parameter int unsigned ACC_WIDTH = 56,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 en;
    logic [1:0]           cfg;
    logic                 in_valid;
    logic                 in_ready;
    logic [INT_WIDTH-1:0] in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;
    logic [1:0]           out_cfg;
    logic                 out_ovf;

    modport slave (
        input  en, cfg, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_cfg, out_ovf
    );

    modport master (
        output en, cfg, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_cfg, out_ovf
    );
endinterface

// File: rtl/mac_acc_block.sv
// Group accumulator behind the multiply block: sums masked products until in_last,
// then holds the saturated sum, beat count, cfg and overflow flag for the next stage.
module mac_acc_block #(
    parameter int unsigned MIN_WIDTH = 8,
    parameter int unsigned INT_WIDTH = 40,
    parameter int unsigned ACC_WIDTH = 56,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    mac_acc_block_if.slave bus
);
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic [INT_WIDTH-1:0] MASK_SINGLE = INT_WIDTH'({(2*MIN_WIDTH){1'b1}});
    localparam logic [INT_WIDTH-1:0] MASK_DUAL   = INT_WIDTH'({(3*MIN_WIDTH){1'b1}});

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           cfg_q, cfg_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic [CNT_WIDTH-1:0] out_count_q;
    logic [1:0]           out_cfg_q;
    logic                 out_ovf_q;

    logic                 ready;
    logic                 accept;
    logic                 first;
    logic                 load_out;
    logic [1:0]           grp_cfg;
    logic [INT_WIDTH-1:0] masked;
    logic [SUM_WIDTH-1:0] sum;

    // Next-state and datapath update; a beat outside ACCUM always opens a new group.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        ovf_d    = ovf_q;
        load_out = 1'b0;
        masked   = '0;

        ready   = rst && bus.en && (state_q != HOLD || bus.out_ready);
        accept  = ready && bus.in_valid;
        first   = (state_q != ACCUM);
        grp_cfg = first ? bus.cfg : cfg_q;

        case (grp_cfg)
            2'b00:   masked = bus.in_data & MASK_SINGLE;
            2'b01:   masked = bus.in_data & MASK_DUAL;
            2'b10:   masked = bus.in_data;
            default: masked = '0;
        endcase

        sum = {1'b0, acc_q} + SUM_WIDTH'(masked);

        if (accept) begin
            if (first) begin
                cfg_d = bus.cfg;
                acc_d = ACC_WIDTH'(masked);
                cnt_d = CNT_WIDTH'(1);
                ovf_d = 1'b0;
            end else begin
                acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                ovf_d = ovf_q | sum[ACC_WIDTH] | (&cnt_q);
            end
            state_d  = bus.in_last ? HOLD : ACCUM;
            load_out = bus.in_last;
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            cfg_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_cfg_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= (state_d == HOLD);
            if (load_out) begin
                out_data_q  <= acc_d;
                out_count_q <= cnt_d;
                out_cfg_q   <= cfg_d;
                out_ovf_q   <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_cfg   = out_cfg_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mac_acc_block.sv
// Bench for mac_acc_block: vector table, random groups against a group-level model,
// and directed backpressure / enable / reset / saturation sequences.
module tb_mac_acc_block;
    logic clk;
    logic rst;

    int checks;
    int failures;

    mac_acc_block_if #(.INT_WIDTH(40), .ACC_WIDTH(56), .CNT_WIDTH(16)) m_if ();
    mac_acc_block_if #(.INT_WIDTH(40), .ACC_WIDTH(40), .CNT_WIDTH(4))  s_if ();

    mac_acc_block #(.MIN_WIDTH(8), .INT_WIDTH(40), .ACC_WIDTH(56), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(m_if)
    );
    mac_acc_block #(.MIN_WIDTH(8), .INT_WIDTH(40), .ACC_WIDTH(40), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .bus(s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cfg;
        logic [39:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [55:0] data;
        logic [15:0] cnt;
        logic [1:0]  cfg;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [2:0]       nb;
        logic [1:0]       cfg0;
        logic [1:0]       cfgn;
        logic [3:0][39:0] d;
        logic [55:0]      e_data;
        logic [15:0]      e_cnt;
        logic [1:0]       e_cfg;
        logic             e_ovf;
    } vec_t;

    beat_t beat_q[$];
    res_t  exp_q[$];
    bit    mon_en;
    bit    hold_prev;
    logic [55:0] prev_data;

    localparam logic [63:0] ACC_MAX = 64'h00FF_FFFF_FFFF_FFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mask_of(input logic [1:0] c, input logic [39:0] d);
        case (c)
            2'd0:    return 64'(d) % 64'h1_0000;
            2'd1:    return 64'(d) % 64'h100_0000;
            2'd2:    return 64'(d);
            default: return 64'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result scoreboard plus stall-stability watch on the main instance.
    always @(negedge clk) begin
        res_t e;
        if (mon_en) begin
            if (hold_prev) begin
                chk("stall_valid", 64'(m_if.out_valid), 64'd1);
                chk("stall_data", 64'(m_if.out_data), 64'(prev_data));
            end
            if (m_if.out_valid && m_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got data 0x%0h, expected no result", m_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data", 64'(m_if.out_data), 64'(e.data));
                    chk("res_count", 64'(m_if.out_count), 64'(e.cnt));
                    chk("res_cfg", 64'(m_if.out_cfg), 64'(e.cfg));
                    chk("res_ovf", 64'(m_if.out_ovf), 64'(e.ovf));
                end
            end
            hold_prev = m_if.out_valid && !m_if.out_ready;
            prev_data = m_if.out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic run_stream(input bit rnd);
        int  cyc;
        bit  acc;
        beat_t b;
        cyc = 0;
        while ((beat_q.size() != 0 || exp_q.size() != 0) && cyc < 20000) begin
            m_if.en        = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
            m_if.out_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            if (beat_q.size() != 0) begin
                b = beat_q[0];
                m_if.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                m_if.cfg      = b.cfg;
                m_if.in_data  = b.data;
                m_if.in_last  = b.last;
            end else begin
                m_if.in_valid = 1'b0;
            end
            @(negedge clk);
            acc = m_if.in_valid && m_if.in_ready;
            step();
            if (acc) void'(beat_q.pop_front());
            cyc++;
        end
        if (cyc >= 20000) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout: got %0d beats and %0d results left, expected 0", beat_q.size(), exp_q.size());
            beat_q.delete();
            exp_q.delete();
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        m_if.en        = 1'b1;
        step();
        step();
    endtask

    task automatic s_beat(input logic [1:0] c, input logic [39:0] d, input logic l);
        s_if.in_valid = 1'b1;
        s_if.cfg      = c;
        s_if.in_data  = d;
        s_if.in_last  = l;
        step();
        s_if.in_valid = 1'b0;
    endtask

    initial begin
        vec_t        tbl[6];
        logic [63:0] r;
        logic [63:0] sum;
        logic [39:0] d;
        logic [1:0]  gc;
        logic        ovf;
        int          nb;

        checks = 0;
        failures = 0;
        mon_en = 1'b0;

        tbl[0] = '{3'd3, 2'd0, 2'd0, {40'h0, 40'h300, 40'h200, 40'h100},
                   56'h600, 16'd3, 2'd0, 1'b0};
        tbl[1] = '{3'd2, 2'd1, 2'd2, {40'h0, 40'h0, 40'h1, 40'hFF_FFFF_FFFF},
                   56'h100_0000, 16'd2, 2'd1, 1'b0};
        tbl[2] = '{3'd2, 2'd3, 2'd0, {40'h0, 40'h0, 40'h9, 40'h5},
                   56'h0, 16'd2, 2'd3, 1'b0};
        tbl[3] = '{3'd1, 2'd2, 2'd0, {40'h0, 40'h0, 40'h0, 40'hFF_FFFF_FFFF},
                   56'hFF_FFFF_FFFF, 16'd1, 2'd2, 1'b0};
        tbl[4] = '{3'd2, 2'd0, 2'd2, {40'h0, 40'h0, 40'hFFFF_FFFF, 40'h12_3456_789A},
                   56'h1_7899, 16'd2, 2'd0, 1'b0};
        tbl[5] = '{3'd4, 2'd1, 2'd3, {40'h100_0001, 40'hFF00_0000, 40'h12_3456_789A, 40'h10},
                   56'h56_78AB, 16'd4, 2'd1, 1'b0};

        rst = 1'b0;
        m_if.en = 1'b1; m_if.cfg = 2'd0; m_if.in_valid = 1'b1; m_if.in_data = 40'h1;
        m_if.in_last = 1'b1; m_if.out_ready = 1'b1;
        s_if.en = 1'b1; s_if.cfg = 2'd0; s_if.in_valid = 1'b0; s_if.in_data = '0;
        s_if.in_last = 1'b0; s_if.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(m_if.in_ready), 64'd0);
        chk("rst_out_valid", 64'(m_if.out_valid), 64'd0);
        chk("rst_out_data", 64'(m_if.out_data), 64'd0);
        chk("rst_out_count", 64'(m_if.out_count), 64'd0);
        chk("rst_out_cfg", 64'(m_if.out_cfg), 64'd0);
        chk("rst_out_ovf", 64'(m_if.out_ovf), 64'd0);
        rst = 1'b1;
        m_if.in_valid = 1'b0;
        step();

        // Vector table, back to back
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < int'(tbl[i].nb); k++)
                beat_q.push_back('{(k == 0) ? tbl[i].cfg0 : tbl[i].cfgn, tbl[i].d[k],
                                   (k == int'(tbl[i].nb) - 1)});
            exp_q.push_back('{tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_cfg, tbl[i].e_ovf});
        end
        run_stream(1'b0);

        // Random groups against the group-level model
        for (int g = 0; g < 80; g++) begin
            nb  = int'($urandom_range(1, 6));
            gc  = 2'($urandom_range(0, 3));
            sum = 64'd0;
            ovf = 1'b0;
            for (int k = 0; k < nb; k++) begin
                r = {$urandom(), $urandom()};
                d = r[39:0];
                if ($urandom_range(0, 3) == 0) d = 40'(d % 40'h100);
                if (k == 0) begin
                    sum = mask_of(gc, d);
                end else begin
                    sum = sum + mask_of(gc, d);
                    if (sum > ACC_MAX) begin
                        sum = ACC_MAX;
                        ovf = 1'b1;
                    end
                end
                beat_q.push_back('{(k == 0) ? gc : 2'($urandom_range(0, 3)), d, (k == nb - 1)});
            end
            exp_q.push_back('{sum[55:0], 16'(nb), gc, ovf});
        end
        run_stream(1'b1);
        mon_en = 1'b0;

        // Stalled output backpressures the input, then overlap with no gap
        m_if.out_ready = 1'b0; m_if.in_valid = 1'b1; m_if.cfg = 2'd0;
        m_if.in_data = 40'h42; m_if.in_last = 1'b1;
        step();
        m_if.in_data = 40'h7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(m_if.in_ready), 64'd0);
            chk("bp_out_valid", 64'(m_if.out_valid), 64'd1);
            chk("bp_out_data", 64'(m_if.out_data), 64'h42);
            step();
        end
        m_if.out_ready = 1'b1;
        @(negedge clk);
        chk("ovl_in_ready", 64'(m_if.in_ready), 64'd1);
        step();
        m_if.in_valid = 1'b0;
        chk("ovl_out_valid", 64'(m_if.out_valid), 64'd1);
        chk("ovl_out_data", 64'(m_if.out_data), 64'h7);
        chk("ovl_out_count", 64'(m_if.out_count), 64'd1);
        step();
        chk("drain_out_valid", 64'(m_if.out_valid), 64'd0);

        // Enable low mid-group freezes the partial sum
        m_if.in_valid = 1'b1; m_if.in_data = 40'h10; m_if.in_last = 1'b0;
        step();
        m_if.en = 1'b0; m_if.in_data = 40'h20; m_if.in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_in_ready", 64'(m_if.in_ready), 64'd0);
            chk("en_out_valid", 64'(m_if.out_valid), 64'd0);
            step();
        end
        m_if.en = 1'b1;
        step();
        m_if.in_valid = 1'b0;
        chk("en_out_data", 64'(m_if.out_data), 64'h30);
        chk("en_out_count", 64'(m_if.out_count), 64'd2);
        step();

        // Reset mid-group discards the partial sum
        m_if.in_valid = 1'b1; m_if.in_data = 40'h50; m_if.in_last = 1'b0;
        step();
        m_if.in_data = 40'h60;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(m_if.in_ready), 64'd0);
        chk("mid_rst_out_valid", 64'(m_if.out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(m_if.out_data), 64'd0);
        chk("mid_rst_out_count", 64'(m_if.out_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        m_if.in_data = 40'h3; m_if.in_last = 1'b1;
        step();
        m_if.in_valid = 1'b0;
        chk("post_rst_out_valid", 64'(m_if.out_valid), 64'd1);
        chk("post_rst_out_data", 64'(m_if.out_data), 64'h3);
        chk("post_rst_out_count", 64'(m_if.out_count), 64'd1);
        step();

        // Narrow instance: sum clamp, exact fit, count hold
        s_beat(2'd2, 40'hFF_FFFF_FFFF, 1'b0);
        s_beat(2'd2, 40'hFF_FFFF_FFFF, 1'b1);
        chk("sat_data", 64'(s_if.out_data), 64'hFF_FFFF_FFFF);
        chk("sat_ovf", 64'(s_if.out_ovf), 64'd1);
        chk("sat_count", 64'(s_if.out_count), 64'd2);
        s_beat(2'd2, 40'hFF_FFFF_FFFE, 1'b0);
        s_beat(2'd2, 40'h1, 1'b1);
        chk("fit_data", 64'(s_if.out_data), 64'hFF_FFFF_FFFF);
        chk("fit_ovf", 64'(s_if.out_ovf), 64'd0);
        for (int k = 0; k < 15; k++) s_beat(2'd0, 40'h1, (k == 14));
        chk("cnt15_count", 64'(s_if.out_count), 64'd15);
        chk("cnt15_ovf", 64'(s_if.out_ovf), 64'd0);
        for (int k = 0; k < 17; k++) s_beat(2'd0, 40'h1, (k == 16));
        chk("cnt17_count", 64'(s_if.out_count), 64'd15);
        chk("cnt17_ovf", 64'(s_if.out_ovf), 64'd1);
        chk("cnt17_data", 64'(s_if.out_data), 64'd17);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
